// File: rtl/wb_regfile_sequencer_pkg.sv
// Shared types and constants for the writeback sequencer and its register scoreboard.
package wb_regfile_sequencer_pkg;

    localparam int NREGS = 16;
    localparam int REGW  = 4;
    localparam int DATAW = 64;

    typedef logic [REGW-1:0]  reg_idx_t;
    typedef logic [DATAW-1:0] reg_data_t;
    typedef logic [NREGS-1:0] reg_vec_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SPEC = 1'b1
    } wb_seq_state_e;

    // A special dest aliasing the primary dest is dropped: the primary result wins.
    function automatic logic spec_write_needed(input logic     spec_valid,
                                               input reg_idx_t spec_dest,
                                               input reg_idx_t dest);
        return spec_valid && (spec_dest != dest);
    endfunction

    function automatic reg_vec_t reg_onehot(input reg_idx_t idx);
        return reg_vec_t'({{(NREGS-1){1'b0}}, 1'b1}) << idx;
    endfunction

endpackage

// File: rtl/wb_regfile_sequencer_reg_scoreboard.sv
// Register in-use bit vector: set at issue, cleared at write retire, flushed on kill.
module reg_scoreboard
    import wb_regfile_sequencer_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     flush_in,
    input  logic     iss_valid_in,
    input  reg_idx_t iss_dest_in,
    input  logic     iss_spec_valid_in,
    input  reg_idx_t iss_spec_dest_in,
    input  logic     clr_valid_in,
    input  reg_idx_t clr_idx_in,
    output logic     iss_conflict_out,
    output reg_vec_t in_use_out
);

    reg_vec_t in_use_q;
    reg_vec_t in_use_d;
    reg_vec_t set_mask_s;
    reg_vec_t clr_mask_s;
    logic     issue_ok_s;

    // Conflict compare and the next in-use vector; set is applied after clear so it wins.
    always_comb begin
        iss_conflict_out = iss_valid_in &
                           (in_use_q[iss_dest_in] |
                            (iss_spec_valid_in & in_use_q[iss_spec_dest_in]));
        issue_ok_s = iss_valid_in & ~iss_conflict_out & ~flush_in;
        set_mask_s = issue_ok_s ?
                     (reg_onehot(iss_dest_in) |
                      (iss_spec_valid_in ? reg_onehot(iss_spec_dest_in) : reg_vec_t'(0))) :
                     reg_vec_t'(0);
        clr_mask_s = clr_valid_in ? reg_onehot(clr_idx_in) : reg_vec_t'(0);
        in_use_d   = flush_in ? reg_vec_t'(0) : ((in_use_q & ~clr_mask_s) | set_mask_s);
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_use_q <= '0;
        end else begin
            in_use_q <= in_use_d;
        end
    end

    assign in_use_out = in_use_q;

endmodule

// File: rtl/wb_regfile_sequencer.sv
// Sequences writeback packets onto the single regfile write port, splitting
// dual-dest packets over two cycles, and retires scoreboard bits as writes land.
module wb_regfile_sequencer
    import wb_regfile_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             kill_in,
    input  logic             iss_valid_in,
    input  logic [REGW-1:0]  iss_dest_in,
    input  logic             iss_spec_valid_in,
    input  logic [REGW-1:0]  iss_spec_dest_in,
    output logic             iss_conflict_out,
    input  logic             wb_valid_in,
    output logic             wb_ready_out,
    input  logic [REGW-1:0]  wb_dest_in,
    input  logic [DATAW-1:0] wb_data_in,
    input  logic             wb_spec_valid_in,
    input  logic [REGW-1:0]  wb_spec_dest_in,
    input  logic [DATAW-1:0] wb_spec_data_in,
    output logic             rf_we_out,
    output logic [REGW-1:0]  rf_waddr_out,
    output logic [DATAW-1:0] rf_wdata_out,
    output logic [NREGS-1:0] in_use_out,
    output logic             wb_done_out
);

    wb_seq_state_e state_q, state_d;
    reg_idx_t      spec_dest_q, spec_dest_d;
    reg_data_t     spec_data_q, spec_data_d;
    logic          rf_we_q, rf_we_d;
    reg_idx_t      rf_waddr_q, rf_waddr_d;
    reg_data_t     rf_wdata_q, rf_wdata_d;
    logic          wb_done_q, wb_done_d;
    logic          accept_s;

    assign wb_ready_out = reset_n & (state_q == IDLE) & ~kill_in;
    assign accept_s     = wb_valid_in & wb_ready_out;

    // Next-state and write-port mux; kill overrides everything and suppresses the write.
    always_comb begin
        state_d     = state_q;
        spec_dest_d = spec_dest_q;
        spec_data_d = spec_data_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        wb_done_d   = 1'b0;
        if (kill_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = wb_dest_in;
                        rf_wdata_d = wb_data_in;
                        if (spec_write_needed(wb_spec_valid_in, wb_spec_dest_in, wb_dest_in)) begin
                            spec_dest_d = wb_spec_dest_in;
                            spec_data_d = wb_spec_data_in;
                            state_d     = SPEC;
                        end else begin
                            wb_done_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                SPEC: begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = spec_dest_q;
                    rf_wdata_d = spec_data_q;
                    wb_done_d  = 1'b1;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state, latched special write and registered write-port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            spec_dest_q <= '0;
            spec_data_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            wb_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            spec_dest_q <= spec_dest_d;
            spec_data_q <= spec_data_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            wb_done_q   <= wb_done_d;
        end
    end

    assign rf_we_out    = rf_we_q;
    assign rf_waddr_out = rf_waddr_q;
    assign rf_wdata_out = rf_wdata_q;
    assign wb_done_out  = wb_done_q;

    // The bit of a register retires at the same edge its write is registered.
    reg_scoreboard u_reg_scoreboard (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush_in          (kill_in),
        .iss_valid_in      (iss_valid_in),
        .iss_dest_in       (iss_dest_in),
        .iss_spec_valid_in (iss_spec_valid_in),
        .iss_spec_dest_in  (iss_spec_dest_in),
        .clr_valid_in      (rf_we_d),
        .clr_idx_in        (rf_waddr_d),
        .iss_conflict_out  (iss_conflict_out),
        .in_use_out        (in_use_out)
    );

endmodule

// File: tb/tb_wb_regfile_sequencer.sv
// Scoreboard bench for wb_regfile_sequencer: directed scenarios then random traffic
// against a packet-level reference model.
module tb_wb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        kill_in;
    logic        iss_valid_in;
    logic [3:0]  iss_dest_in;
    logic        iss_spec_valid_in;
    logic [3:0]  iss_spec_dest_in;
    logic        iss_conflict_out;
    logic        wb_valid_in;
    logic        wb_ready_out;
    logic [3:0]  wb_dest_in;
    logic [63:0] wb_data_in;
    logic        wb_spec_valid_in;
    logic [3:0]  wb_spec_dest_in;
    logic [63:0] wb_spec_data_in;
    logic        rf_we_out;
    logic [3:0]  rf_waddr_out;
    logic [63:0] rf_wdata_out;
    logic [15:0] in_use_out;
    logic        wb_done_out;

    wb_regfile_sequencer dut (
        .clk(clk), .reset_n(reset_n), .kill_in(kill_in),
        .iss_valid_in(iss_valid_in), .iss_dest_in(iss_dest_in),
        .iss_spec_valid_in(iss_spec_valid_in), .iss_spec_dest_in(iss_spec_dest_in),
        .iss_conflict_out(iss_conflict_out),
        .wb_valid_in(wb_valid_in), .wb_ready_out(wb_ready_out),
        .wb_dest_in(wb_dest_in), .wb_data_in(wb_data_in),
        .wb_spec_valid_in(wb_spec_valid_in), .wb_spec_dest_in(wb_spec_dest_in),
        .wb_spec_data_in(wb_spec_data_in),
        .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out), .rf_wdata_out(rf_wdata_out),
        .in_use_out(in_use_out), .wb_done_out(wb_done_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
        logic        done;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: outstanding special write and set of registers with pending producers.
    logic        m_busy = 1'b0;
    logic [3:0]  m_sd   = 4'd0;
    logic [63:0] m_sdat = 64'd0;
    logic [15:0] m_in_use = 16'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every registered write must match the next expected write, in order.
    always @(negedge clk) begin
        wr_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", {63'd0, rf_we_out}, 64'd1);
            chk("rf_waddr", {60'd0, rf_waddr_out}, {60'd0, e.addr});
            chk("rf_wdata", rf_wdata_out, e.data);
            chk("wb_done", {63'd0, wb_done_out}, {63'd0, e.done});
        end else begin
            chk("idle_we", {63'd0, rf_we_out}, 64'd0);
            chk("idle_done", {63'd0, wb_done_out}, 64'd0);
        end
        chk("in_use", {48'd0, in_use_out}, {48'd0, m_in_use});
    end

    task automatic step(input logic k, input logic iv, input logic [3:0] id,
                        input logic isv, input logic [3:0] isd,
                        input logic wv, input logic [3:0] wd, input logic [63:0] wdat,
                        input logic wsv, input logic [3:0] wsd, input logic [63:0] wsdat);
        logic exp_conf, exp_ready, split;
        kill_in = k; iss_valid_in = iv; iss_dest_in = id;
        iss_spec_valid_in = isv; iss_spec_dest_in = isd;
        wb_valid_in = wv; wb_dest_in = wd; wb_data_in = wdat;
        wb_spec_valid_in = wsv; wb_spec_dest_in = wsd; wb_spec_data_in = wsdat;
        #1;
        exp_conf  = iv && (m_in_use[id] || (isv && m_in_use[isd]));
        exp_ready = reset_n && !m_busy && !k;
        chk("conflict", {63'd0, iss_conflict_out}, {63'd0, exp_conf});
        chk("ready", {63'd0, wb_ready_out}, {63'd0, exp_ready});
        @(posedge clk);
        if (!reset_n || k) begin
            m_busy   = 1'b0;
            m_in_use = 16'd0;
        end else begin
            if (m_busy) begin
                exp_q.push_back('{m_sd, m_sdat, 1'b1});
                m_in_use[m_sd] = 1'b0;
                m_busy = 1'b0;
            end else if (wv) begin
                split = wsv && (wsd != wd);
                exp_q.push_back('{wd, wdat, !split});
                m_in_use[wd] = 1'b0;
                if (split) begin
                    m_busy = 1'b1;
                    m_sd   = wsd;
                    m_sdat = wsdat;
                end
            end
            if (iv && !exp_conf) begin
                m_in_use[id] = 1'b1;
                if (isv) m_in_use[isd] = 1'b1;
            end
        end
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        kill_in = 0; iss_valid_in = 0; iss_dest_in = 0; iss_spec_valid_in = 0;
        iss_spec_dest_in = 0; wb_valid_in = 0; wb_dest_in = 0; wb_data_in = 0;
        wb_spec_valid_in = 0; wb_spec_dest_in = 0; wb_spec_data_in = 0;
        #3;
        chk("rst_ready", {63'd0, wb_ready_out}, 64'd0);
        chk("rst_we", {63'd0, rf_we_out}, 64'd0);
        chk("rst_in_use", {48'd0, in_use_out}, 64'd0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;

        // Single write with scoreboard retire.
        step(0, 1, 4'd3, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        step(0, 0, 0, 0, 0, 1, 4'd3, 64'hAA, 0, 0, 64'd0);
        idle(1);
        // Split packet.
        step(0, 0, 0, 0, 0, 1, 4'd0, 64'h1111, 1, 4'd2, 64'h2222);
        idle(2);
        // Aliased special dest collapses to one write.
        step(0, 0, 0, 0, 0, 1, 4'd5, 64'h5555, 1, 4'd5, 64'h6666);
        idle(1);
        // Issue and retire of reg 7 at the same edge, then conflicting re-issue.
        step(0, 1, 4'd7, 0, 0, 1, 4'd7, 64'h77, 0, 0, 64'd0);
        step(0, 1, 4'd7, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        chk("in_use7", {63'd0, in_use_out[7]}, 64'd1);
        // Kill during SPEC with regs 0..7 busy.
        for (int r = 0; r < 8; r++) step(0, 1, 4'(r), 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        chk("in_use_ff", {48'd0, in_use_out}, 64'h00FF);
        step(0, 0, 0, 0, 0, 1, 4'd8, 64'h88, 1, 4'd9, 64'h99);
        step(1, 1, 4'd12, 0, 0, 1, 4'd10, 64'hAB, 0, 0, 64'd0);
        idle(2);
        // Asynchronous reset while in SPEC.
        step(0, 1, 4'd4, 0, 0, 1, 4'd1, 64'h1, 1, 4'd4, 64'h4);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        m_busy = 1'b0; m_in_use = 16'd0;
        chk("arst_we", {63'd0, rf_we_out}, 64'd0);
        chk("arst_addr", {60'd0, rf_waddr_out}, 64'd0);
        chk("arst_data", rf_wdata_out, 64'd0);
        chk("arst_done", {63'd0, wb_done_out}, 64'd0);
        chk("arst_in_use", {48'd0, in_use_out}, 64'd0);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom},
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom});
        end
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
